// File: rtl/aes_cipher_top.sv
// ---------------------------------------------------------------------------
// aes_cipher_top -- AES-128 forward cipher, one round per clock.
//
// Ports
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous active-low reset
//   ld        in   1    load strobe: samples key/text_in and (re)starts a block
//   key       in   128  cipher key (only meaningful on an ld edge)
//   text_in   in   128  plaintext block (only meaningful on an ld edge)
//   text_out  out  128  ciphertext of the last completed block
//   done      out  1    one-cycle pulse, coincident with a text_out update
//   busy      out  1    high while rounds are in progress
//
// Handshake: ld is a fire-and-forget strobe with no back-pressure. Any ld edge
// always wins; it restarts the core even while busy, which discards the
// block in flight. A block that reaches its final round on the same edge as
// a new ld still completes (done=1, text_out updated) and the new block
// starts on that edge. done is the only "valid" for text_out and is high for
// exactly one cycle; no ready exists on the output side.
//
// Byte order is FIPS-197 column-major: byte n = bits [127-8n -: 8],
// column c = bytes 4c..4c+3, row r of column c = byte 4c+r.
//
// aes_sbox (the shared S-box leaf) lives in this file as well so the core
// is self-contained.
// ---------------------------------------------------------------------------

// aes_sbox: forward AES S-box lookup.
//   a  in   8  input byte
//   d  out  8  substituted byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  // Row-major FIPS-197 S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = 11'd2047 - {a, 3'b000};
  assign d   = SBOX[idx -: 8];

endmodule

module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Control state is kept in plainly named registers (fsm, rcnt) so that
  // checkers can bind to them directly.
  fsm_t         fsm;
  logic [3:0]   rcnt;      // round about to be applied on the next edge
  logic [127:0] st;        // cipher state
  logic [127:0] rk;        // round key k(rcnt-1)

  // -------------------------------------------------------------------------
  // GF(2^8) helpers
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // On-the-fly key schedule: k(rcnt) from k(rcnt-1)
  // -------------------------------------------------------------------------
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [127:0] rk_next;

  assign rot_w3 = {rk[23:0], rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a (rot_w3[31-8*i -: 8]),
      .d (sub_w3[31-8*i -: 8])
    );
  end

  assign kw0     = rk[127:96] ^ sub_w3 ^ {rcon(rcnt), 24'h0};
  assign kw1     = rk[95:64]  ^ kw0;
  assign kw2     = rk[63:32]  ^ kw1;
  assign kw3     = rk[31:0]   ^ kw2;
  assign rk_next = {kw0, kw1, kw2, kw3};

  // -------------------------------------------------------------------------
  // Round data path: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
  // -------------------------------------------------------------------------
  logic [127:0] sb_flat;
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;
  logic [127:0] round_out;

  for (genvar n = 0; n < 16; n++) begin : g_data_sbox
    aes_sbox u_sbox (
      .a (st[127-8*n -: 8]),
      .d (sb_flat[127-8*n -: 8])
    );
  end

  // Row r of column c takes the byte from column (c+r) mod 4 of the same row.
  always_comb begin
    sr_flat = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_flat[127-8*(4*c+r) -: 8] = sb_flat[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mc_flat = '0;
    for (int c = 0; c < 4; c++) begin
      mc_flat[127-32*c -: 32] = mix_col(sr_flat[127-32*c -: 32]);
    end
  end

  // The final round skips MixColumns.
  assign round_out = ((rcnt == 4'd10) ? sr_flat : mc_flat) ^ rk_next;

  // -------------------------------------------------------------------------
  // Control FSM and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= IDLE;
      rcnt     <= 4'd0;
      st       <= '0;
      rk       <= '0;
      text_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;

      // A block finishing on this edge always completes, even if ld also
      // fires here and immediately starts the next block.
      if (fsm == RUN && rcnt == 4'd10) begin
        text_out <= round_out;
        done     <= 1'b1;
      end

      if (ld) begin
        st   <= text_in ^ key;
        rk   <= key;
        rcnt <= 4'd1;
        busy <= 1'b1;
        fsm  <= RUN;
      end else if (fsm == RUN) begin
        st <= round_out;
        rk <= rk_next;
        if (rcnt == 4'd10) begin
          rcnt <= 4'd0;
          busy <= 1'b0;
          fsm  <= IDLE;
        end else begin
          rcnt <= rcnt + 4'd1;
        end
      end
    end
  end

endmodule
